// File: rtl/dbi_tx_phy.sv
// MIPI-DBI Type-B (8080, write-only) pin driver: serialises command/data beats into CSX/DCX/WRX/D strobes and generates RESX.
// Optional debug byte counter output is built when DBI_TX_PHY_BYTE_CNT_EN is defined.
module dbi_tx_phy #(
    parameter int DBI_IF_D_W  = 8,
    parameter int WR_LOW_CYC  = 2,
    parameter int WR_HIGH_CYC = 2,
    parameter int HRST_CYC    = 1250
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dtp_dbi_hrst_i,
    input  logic [DBI_IF_D_W-1:0] dtp_tx_cmd_typ_i,
    input  logic [DBI_IF_D_W-1:0] dtp_tx_cmd_dat_i,
    input  logic                  dtp_tx_last_i,
    input  logic                  dtp_tx_no_dat_i,
    input  logic                  dtp_tx_vld_i,
    output logic                  dtp_tx_rdy_o,
    output logic                  dbi_csx_o,
    output logic                  dbi_dcx_o,
    output logic                  dbi_wrx_o,
    output logic                  dbi_rdx_o,
    output logic                  dbi_resx_o,
`ifdef DBI_TX_PHY_BYTE_CNT_EN
    output logic [31:0]           dbg_byte_cnt_o,
`endif
    output logic [DBI_IF_D_W-1:0] dbi_d_o
);

    // state  | meaning
    // IDLE   | CS released, waiting for first beat of a transaction
    // HRST   | RESX held low for HRST_CYC cycles
    // CMD_LO | command byte on bus, WRX low
    // CMD_HI | command byte on bus, WRX high (panel latched on rising edge)
    // DAT_LO | data byte on bus, WRX low
    // DAT_HI | data byte on bus, WRX high
    // WAIT   | CS held low between data beats of one transaction
    // END    | one-cycle CS-high gap before IDLE
    typedef enum logic [2:0] {
        S_IDLE, S_HRST, S_CMD_LO, S_CMD_HI, S_DAT_LO, S_DAT_HI, S_WAIT, S_END
    } state_t;

    localparam int MAX_WR  = (WR_LOW_CYC > WR_HIGH_CYC) ? WR_LOW_CYC : WR_HIGH_CYC;
    localparam int MAX_CYC = (MAX_WR > HRST_CYC) ? MAX_WR : HRST_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] LD_LO   = CNT_W'(WR_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] LD_HI   = CNT_W'(WR_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] LD_HRST = CNT_W'(HRST_CYC - 1);

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_csx;
    logic                  r_dcx;
    logic                  r_wrx;
    logic                  r_resx;
    logic [DBI_IF_D_W-1:0] r_d;
    logic [DBI_IF_D_W-1:0] r_dat;
    logic                  r_last;
    logic                  r_no_dat;

    logic w_acc;
    logic w_cnt_zero;

    assign dtp_tx_rdy_o = rst_n & ((r_state == S_IDLE) | (r_state == S_WAIT));
    assign w_acc        = dtp_tx_vld_i & dtp_tx_rdy_o;
    assign w_cnt_zero   = (r_cnt == '0);

    assign dbi_csx_o  = r_csx;
    assign dbi_dcx_o  = r_dcx;
    assign dbi_wrx_o  = r_wrx;
    assign dbi_rdx_o  = 1'b1;
    assign dbi_resx_o = r_resx;
    assign dbi_d_o    = r_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_csx    <= 1'b1;
            r_dcx    <= 1'b1;
            r_wrx    <= 1'b1;
            r_resx   <= 1'b1;
            r_d      <= '0;
            r_dat    <= '0;
            r_last   <= 1'b0;
            r_no_dat <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        if (dtp_dbi_hrst_i) begin
                            r_state <= S_HRST;
                            r_resx  <= 1'b0;
                            r_cnt   <= LD_HRST;
                        end else begin
                            r_state  <= S_CMD_LO;
                            r_csx    <= 1'b0;
                            r_wrx    <= 1'b0;
                            r_dcx    <= 1'b0;
                            r_d      <= dtp_tx_cmd_typ_i;
                            r_dat    <= dtp_tx_cmd_dat_i;
                            r_last   <= dtp_tx_last_i;
                            r_no_dat <= dtp_tx_no_dat_i;
                            r_cnt    <= LD_LO;
                        end
                    end
                end
                S_HRST: begin
                    if (w_cnt_zero) begin
                        r_state <= S_IDLE;
                        r_resx  <= 1'b1;
                        r_dcx   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_CMD_LO, S_DAT_LO: begin
                    if (w_cnt_zero) begin
                        r_state <= (r_state == S_CMD_LO) ? S_CMD_HI : S_DAT_HI;
                        r_wrx   <= 1'b1;
                        r_cnt   <= LD_HI;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_CMD_HI: begin
                    if (w_cnt_zero) begin
                        if (r_no_dat) begin
                            r_state <= S_END;
                            r_csx   <= 1'b1;
                        end else begin
                            r_state <= S_DAT_LO;
                            r_wrx   <= 1'b0;
                            r_dcx   <= 1'b1;
                            r_d     <= r_dat;
                            r_cnt   <= LD_LO;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_DAT_HI: begin
                    if (w_cnt_zero) begin
                        if (r_last) begin
                            r_state <= S_END;
                            r_csx   <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    // Follow-on beats never resend the command byte.
                    if (w_acc) begin
                        if (dtp_dbi_hrst_i) begin
                            r_state <= S_HRST;
                            r_csx   <= 1'b1;
                            r_resx  <= 1'b0;
                            r_cnt   <= LD_HRST;
                        end else if (dtp_tx_no_dat_i) begin
                            r_state <= S_END;
                            r_csx   <= 1'b1;
                        end else begin
                            r_state <= S_DAT_LO;
                            r_wrx   <= 1'b0;
                            r_dcx   <= 1'b1;
                            r_d     <= dtp_tx_cmd_dat_i;
                            r_last  <= dtp_tx_last_i;
                            r_cnt   <= LD_LO;
                        end
                    end
                end
                S_END: begin
                    r_state <= S_IDLE;
                    r_dcx   <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DBI_TX_PHY_BYTE_CNT_EN
    logic [31:0] r_byte_cnt;
    logic        w_wr_rise;

    // The WRX rising edge is the last cycle of a low phase.
    assign w_wr_rise      = ((r_state == S_CMD_LO) | (r_state == S_DAT_LO)) & w_cnt_zero;
    assign dbg_byte_cnt_o = r_byte_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_byte_cnt <= '0;
        end else if (w_wr_rise) begin
            r_byte_cnt <= r_byte_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dbi_tx_phy.sv
// Self-checking bench for dbi_tx_phy: per-cycle pin waveform model, vector table, corner sequences, random beats.
module tb_dbi_tx_phy;

    localparam int W  = 8;
    localparam int WL = 2;
    localparam int WH = 2;
    localparam int HR = 1250;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         hrst_i = 1'b0;
    logic [W-1:0] cmd_i = '0;
    logic [W-1:0] dat_i = '0;
    logic         last_i = 1'b0;
    logic         no_dat_i = 1'b0;
    logic         vld_i = 1'b0;
    logic         rdy_o;
    logic         csx_o, dcx_o, wrx_o, rdx_o, resx_o;
    logic [W-1:0] d_o;
`ifdef DBI_TX_PHY_BYTE_CNT_EN
    logic [31:0]  dbg_cnt_o;
`endif

    dbi_tx_phy #(
        .DBI_IF_D_W (W),
        .WR_LOW_CYC (WL),
        .WR_HIGH_CYC(WH),
        .HRST_CYC   (HR)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .dtp_dbi_hrst_i  (hrst_i),
        .dtp_tx_cmd_typ_i(cmd_i),
        .dtp_tx_cmd_dat_i(dat_i),
        .dtp_tx_last_i   (last_i),
        .dtp_tx_no_dat_i (no_dat_i),
        .dtp_tx_vld_i    (vld_i),
        .dtp_tx_rdy_o    (rdy_o),
        .dbi_csx_o       (csx_o),
        .dbi_dcx_o       (dcx_o),
        .dbi_wrx_o       (wrx_o),
        .dbi_rdx_o       (rdx_o),
        .dbi_resx_o      (resx_o),
`ifdef DBI_TX_PHY_BYTE_CNT_EN
        .dbg_byte_cnt_o  (dbg_cnt_o),
`endif
        .dbi_d_o         (d_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           hrst;
        logic [W-1:0] cmd;
        logic [W-1:0] dat;
        bit           last;
        bit           no_dat;
    } beat_t;

    typedef struct {
        bit           csx;
        bit           dcx;
        bit           wrx;
        bit           resx;
        bit           rdy;
        logic [W-1:0] d;
        int unsigned  bcnt;
    } exp_t;

    typedef struct {
        beat_t b;
        int    busy;
        int    strobes;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    int n_cyc   = 0;

    // Reference model: queue of expected pin states for the cycles after an accepted beat.
    exp_t         exp_q[$];
    bit           m_in_txn = 1'b0;
    bit           m_dcx = 1'b1;
    logic [W-1:0] m_d = '0;
    int unsigned  m_bcnt = 0;

    int st_busy, st_rise, st_cmd_rise, st_csx_hi;
    bit prev_wrx = 1'b1;

    task automatic push(input bit csx, input bit dcx, input bit wrx, input bit resx, input logic [W-1:0] d);
        exp_t e;
        e.csx = csx; e.dcx = dcx; e.wrx = wrx; e.resx = resx; e.rdy = 1'b0; e.d = d; e.bcnt = m_bcnt;
        exp_q.push_back(e);
    endtask

    task automatic strobe(input logic [W-1:0] b, input bit dc);
        m_d = b;
        m_dcx = dc;
        repeat (WL) push(1'b0, dc, 1'b0, 1'b1, b);
        m_bcnt++;
        repeat (WH) push(1'b0, dc, 1'b1, 1'b1, b);
    endtask

    task automatic end_txn();
        push(1'b1, m_dcx, 1'b1, 1'b1, m_d);
        m_dcx = 1'b1;
        m_in_txn = 1'b0;
    endtask

    task automatic gen(input beat_t b);
        if (b.hrst) begin
            repeat (HR) push(1'b1, m_dcx, 1'b1, 1'b0, m_d);
            m_dcx = 1'b1;
            m_in_txn = 1'b0;
        end else begin
            if (!m_in_txn) strobe(b.cmd, 1'b0);
            if (b.no_dat) begin
                end_txn();
            end else begin
                strobe(b.dat, 1'b1);
                if (b.last) end_txn();
                else m_in_txn = 1'b1;
            end
        end
    endtask

    task automatic drive_garbage();
        vld_i    = $urandom_range(0, 1) == 1;
        hrst_i   = $urandom_range(0, 1) == 1;
        cmd_i    = W'($urandom);
        dat_i    = W'($urandom);
        last_i   = $urandom_range(0, 1) == 1;
        no_dat_i = $urandom_range(0, 1) == 1;
    endtask

    task automatic check(input exp_t e);
        bit bad;
        bad = (csx_o !== e.csx) || (dcx_o !== e.dcx) || (wrx_o !== e.wrx) || (rdx_o !== 1'b1) ||
              (resx_o !== e.resx) || (d_o !== e.d) || (rdy_o !== e.rdy);
`ifdef DBI_TX_PHY_BYTE_CNT_EN
        bad = bad || (dbg_cnt_o !== e.bcnt);
`endif
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL pins cyc=%0d got csx=%b dcx=%b wrx=%b rdx=%b resx=%b d=%02h rdy=%b required csx=%b dcx=%b wrx=%b rdx=1 resx=%b d=%02h rdy=%b bcnt=%0d",
                     n_cyc, csx_o, dcx_o, wrx_o, rdx_o, resx_o, d_o, rdy_o,
                     e.csx, e.dcx, e.wrx, e.resx, e.d, e.rdy, e.bcnt);
        end
    endtask

    task automatic run_cycle(input bit have, input beat_t b, output bit acc);
        exp_t e;
        @(negedge clk);
        n_cyc++;
        acc = 1'b0;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            drive_garbage();
        end else begin
            e.csx = !m_in_txn; e.dcx = m_in_txn ? m_dcx : 1'b1; e.wrx = 1'b1; e.resx = 1'b1;
            e.rdy = 1'b1; e.d = m_d; e.bcnt = m_bcnt;
            drive_garbage();
            if (have) begin
                vld_i = 1'b1; hrst_i = b.hrst; cmd_i = b.cmd; dat_i = b.dat;
                last_i = b.last; no_dat_i = b.no_dat;
                acc = 1'b1;
            end else begin
                vld_i = 1'b0;
            end
        end
        check(e);
        if (rdy_o == 1'b0) st_busy++;
        if (!prev_wrx && wrx_o) begin
            st_rise++;
            if (!dcx_o) st_cmd_rise++;
        end
        if (csx_o) st_csx_hi++;
        prev_wrx = wrx_o;
        if (acc) gen(b);
    endtask

    task automatic send(input beat_t b);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 5000 && !acc; i++) run_cycle(1'b1, b, acc);
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout got not_accepted required accepted");
        end
    endtask

    task automatic drain();
        beat_t nb;
        bit acc;
        nb = '{default: '0};
        while (exp_q.size() > 0) run_cycle(1'b0, nb, acc);
    endtask

    task automatic idle(input int n);
        beat_t nb;
        bit acc;
        nb = '{default: '0};
        repeat (n) run_cycle(1'b0, nb, acc);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        vld_i = 1'b1;
        hrst_i = 1'b1;
        cmd_i = 8'hA5;
        dat_i = 8'h5A;
        exp_q.delete();
        m_in_txn = 1'b0; m_dcx = 1'b1; m_d = '0; m_bcnt = 0;
        repeat (n) begin
            @(negedge clk);
            n_cyc++;
            n_tests++;
            if (csx_o !== 1'b1 || dcx_o !== 1'b1 || wrx_o !== 1'b1 || rdx_o !== 1'b1 ||
                resx_o !== 1'b1 || d_o !== '0 || rdy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_pins got csx=%b dcx=%b wrx=%b rdx=%b resx=%b d=%02h rdy=%b required 1 1 1 1 1 00 0",
                         csx_o, dcx_o, wrx_o, rdx_o, resx_o, d_o, rdy_o);
            end
            prev_wrx = wrx_o;
        end
        rst_n = 1'b1;
        vld_i = 1'b0;
    endtask

    function automatic beat_t mk(input bit hrst, input logic [W-1:0] cmd, input logic [W-1:0] dat,
                                 input bit last, input bit no_dat);
        beat_t b;
        b.hrst = hrst; b.cmd = cmd; b.dat = dat; b.last = last; b.no_dat = no_dat;
        return b;
    endfunction

    task automatic expect_int(input string name, input int got, input int req);
        n_tests++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s got %0d required %0d", name, got, req);
        end
    endtask

    vec_t vecs[5];

    initial begin
        beat_t b;
        vecs[0] = '{b: mk(1'b0, 8'h36, 8'h48, 1'b1, 1'b0), busy: 2*(WL+WH)+1, strobes: 2};
        vecs[1] = '{b: mk(1'b0, 8'h29, 8'hEE, 1'b1, 1'b1), busy: (WL+WH)+1,   strobes: 1};
        vecs[2] = '{b: mk(1'b0, 8'h28, 8'hDD, 1'b0, 1'b1), busy: (WL+WH)+1,   strobes: 1};
        vecs[3] = '{b: mk(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0), busy: HR,          strobes: 0};
        vecs[4] = '{b: mk(1'b0, 8'hA5, 8'h5A, 1'b1, 1'b0), busy: 2*(WL+WH)+1, strobes: 2};

        do_reset(3);
        idle(2);

        foreach (vecs[i]) begin
            st_busy = 0; st_rise = 0; st_cmd_rise = 0; st_csx_hi = 0;
            send(vecs[i].b);
            drain();
            expect_int($sformatf("vec%0d_busy", i), st_busy, vecs[i].busy);
            expect_int($sformatf("vec%0d_strobes", i), st_rise, vecs[i].strobes);
            idle(1);
        end

        // Stream: one command strobe, three data strobes, CS low until END.
        do_reset(2);
        send(mk(1'b0, 8'h2C, 8'h11, 1'b0, 1'b0));
        st_busy = 0; st_rise = 0; st_cmd_rise = 0; st_csx_hi = 0;
        send(mk(1'b0, 8'hFF, 8'h22, 1'b0, 1'b0));
        send(mk(1'b0, 8'h2C, 8'h33, 1'b1, 1'b0));
        drain();
        expect_int("stream_strobes", st_rise, 4);
        expect_int("stream_cmd_strobes", st_cmd_rise, 1);
        expect_int("stream_csx_high", st_csx_hi, 1);
`ifdef DBI_TX_PHY_BYTE_CNT_EN
        expect_int("stream_byte_cnt", int'(dbg_cnt_o), 4);
`endif
        idle(2);

        // Hardware reset requested while holding CS in WAIT.
        send(mk(1'b0, 8'h3A, 8'h01, 1'b0, 1'b0));
        drain();
        idle(2);
        send(mk(1'b1, 8'h00, 8'h00, 1'b0, 1'b0));
        drain();
        idle(1);

        // WAIT closed by a no-data beat.
        send(mk(1'b0, 8'h2A, 8'h10, 1'b0, 1'b0));
        send(mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1));
        drain();
        idle(1);

        // Reset mid-strobe aborts immediately.
        send(mk(1'b0, 8'h55, 8'h66, 1'b1, 1'b0));
        idle(1);
        do_reset(1);
        idle(2);

        // Random beats against the model.
        for (int i = 0; i < 300; i++) begin
            b.hrst   = ($urandom_range(0, 31) == 0);
            b.cmd    = W'($urandom);
            b.dat    = W'($urandom);
            b.last   = ($urandom_range(0, 2) == 0);
            b.no_dat = ($urandom_range(0, 4) == 0);
            send(b);
            if ($urandom_range(0, 3) == 0) begin
                drain();
                idle($urandom_range(0, 2));
            end
        end
        drain();
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
